baud_gen_frac: RTL and testbench

Parametrised successor to the team's fixed 11-bit baud tick generator. It adds:
- a fractional divisor, accumulated so the average tick period is exactly the programmed value;
- an oversample sub-counter that produces a per-bit strobe;
- glitch-free runtime divisor reload;
- a resync input that lets the UART RX realign phase on a start-bit edge.

It drives the oversampled `tick` consumed by `uart_rx`/`uart_tx`, plus `bit_tick` for TX bit timing.

---
 rtl/baud_gen_frac.sv | 125 ++++++++++++
 tb/tb_baud_gen_frac.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud tick generator: oversample tick, per-bit strobe, shadowed
// divisor reload and phase resync for UART RX/TX.
module baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int DEF_INT  = 54,
  parameter int DEF_FRAC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DIV_W-1:0]  dvsr_int,
  input  logic [FRAC_W-1:0] dvsr_frac,
  input  logic              load,
  input  logic              resync,
  output logic              tick,
  output logic              bit_tick,
  output logic              busy_reload
);

  localparam int                 SUB_W      = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(OSR - 1);
  localparam logic [DIV_W-1:0]   DEF_INT_V  = DIV_W'(DEF_INT);
  localparam logic [FRAC_W-1:0]  DEF_FRAC_V = FRAC_W'(DEF_FRAC);

  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [DIV_W-1:0]  int_act_q, int_act_d, int_shd_q, int_shd_d;
  logic [FRAC_W-1:0] frac_act_q, frac_act_d, frac_shd_q, frac_shd_d;
  logic              pend_q, pend_d;
  logic              tick_q, tick_d;
  logic              bit_q, bit_d;

  logic [DIV_W:0]    limit;
  logic              wrap;
  logic [FRAC_W:0]   acc_sum;
  logic              activate;

  // One extra bit on the limit so int_act = all-ones plus a carry cannot wrap.
  assign limit    = {1'b0, int_act_q} + (DIV_W+1)'(extra_q);
  assign wrap     = (cnt_q == limit);
  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_act_q};
  // A load on the activation cycle itself defers to the following boundary.
  assign activate = pend_q && !load && !resync && (!en || wrap);

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    extra_d    = extra_q;
    sub_d      = sub_q;
    int_act_d  = int_act_q;
    frac_act_d = frac_act_q;
    int_shd_d  = int_shd_q;
    frac_shd_d = frac_shd_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    bit_d      = 1'b0;

    if (load) begin
      int_shd_d  = dvsr_int;
      frac_shd_d = dvsr_frac;
      pend_d     = 1'b1;
    end

    if (resync) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      sub_d   = '0;
    end else if (en) begin
      if (wrap) begin
        cnt_d   = '0;
        acc_d   = acc_sum[FRAC_W-1:0];
        extra_d = acc_sum[FRAC_W];
        sub_d   = (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
        tick_d  = 1'b1;
        bit_d   = (sub_q == SUB_LAST);
      end else begin
        cnt_d = cnt_q + (DIV_W+1)'(1);
      end
    end

    if (activate) begin
      int_act_d  = int_shd_q;
      frac_act_d = frac_shd_q;
      pend_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      extra_q    <= 1'b0;
      sub_q      <= '0;
      int_act_q  <= DEF_INT_V;
      frac_act_q <= DEF_FRAC_V;
      int_shd_q  <= DEF_INT_V;
      frac_shd_q <= DEF_FRAC_V;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      extra_q    <= extra_d;
      sub_q      <= sub_d;
      int_act_q  <= int_act_d;
      frac_act_q <= frac_act_d;
      int_shd_q  <= int_shd_d;
      frac_shd_q <= frac_shd_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
    end
  end

  assign tick        = tick_q;
  assign bit_tick    = bit_q;
  assign busy_reload = pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: divisor table plus hand-built corner sequences.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        reset, en, load, resync;
  logic [15:0] dvsr_int;
  logic [3:0]  dvsr_frac;
  logic        tick, bit_tick, busy_reload;

  logic        en1 = 1'b1, load1 = 1'b0, resync1 = 1'b0;
  logic [15:0] dvsr_int1 = 16'd0;
  logic [3:0]  dvsr_frac1 = 4'd0;
  logic        tick1, bit_tick1, busy1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  baud_gen_frac #(.DIV_W(16), .FRAC_W(4), .OSR(16), .DEF_INT(54), .DEF_FRAC(0)) u_dut (
    .clk(clk), .reset(reset), .en(en), .dvsr_int(dvsr_int), .dvsr_frac(dvsr_frac),
    .load(load), .resync(resync), .tick(tick), .bit_tick(bit_tick), .busy_reload(busy_reload)
  );

  baud_gen_frac #(.DIV_W(16), .FRAC_W(4), .OSR(1), .DEF_INT(0), .DEF_FRAC(0)) u_dut_osr1 (
    .clk(clk), .reset(reset), .en(en1), .dvsr_int(dvsr_int1), .dvsr_frac(dvsr_frac1),
    .load(load1), .resync(resync1), .tick(tick1), .bit_tick(bit_tick1), .busy_reload(busy1)
  );

  typedef struct {
    int dv_int;
    int dv_frac;
    int nper;
    int exp_sum;
    int exp_long;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts posedges until tick is seen; -1 if the budget runs out.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < limit);
    if (!tick) n = -1;
  endtask

  initial begin
    vec_t vecs[6];
    int n, sum, nlong, early, bad;

    vecs[0] = '{54, 0, 32, 1760, 0};
    vecs[1] = '{54, 8, 32, 1776, 16};
    vecs[2] = '{54, 15, 16, 895, 15};
    vecs[3] = '{9, 0, 8, 80, 0};
    vecs[4] = '{0, 0, 16, 16, 0};
    vecs[5] = '{0, 8, 16, 24, 8};

    reset = 1'b1; en = 1'b0; load = 1'b0; resync = 1'b0;
    dvsr_int = '0; dvsr_frac = '0;
    step(); step();
    check("reset_tick", tick, 0);
    check("reset_bit_tick", bit_tick, 0);
    check("reset_busy", busy_reload, 0);
    reset = 1'b0;

    // OSR=1, int=0: tick and bit_tick every cycle
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (!(tick1 && bit_tick1)) bad++;
    end
    check("osr1_every_cycle", bad, 0);
    check("idle_no_tick", tick, 0);

    // Integer period 55, bit_tick on 16th tick
    en = 1'b1;
    sum = 0; early = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(100, n);
      if (k == 1) check("first_period", n, 55);
      sum += (n < 0) ? 100000 : n;
      if (k < 16) early += bit_tick;
      else check("bit_tick_16th", bit_tick, 1);
    end
    check("sum_16_ticks", sum, 880);
    check("bit_tick_early", early, 0);
    n = 0;
    do begin step(); n++; end while (!bit_tick && n < 1000);
    check("bit_period", n, 880);
    check("bit_with_tick", tick, 1);
    $display("int period: 16 ticks in %0d cycles", sum);

    // Glitch-free reload at cnt=20
    repeat (20) step();
    dvsr_int = 16'd9; load = 1'b1;
    step();
    load = 1'b0;
    check("busy_after_load", busy_reload, 1);
    n = 21; bad = 0;
    while (1) begin
      step(); n++;
      if (tick || n > 200) break;
      if (!busy_reload) bad++;
    end
    check("reload_old_period", n, 55);
    check("busy_held", bad, 0);
    check("busy_clear_at_boundary", busy_reload, 0);
    wait_tick(100, n); check("reload_new_period_a", n, 10);
    wait_tick(100, n); check("reload_new_period_b", n, 10);

    // Load coincident with the boundary cycle defers activation
    repeat (9) step();
    dvsr_int = 16'd4; load = 1'b1;
    step();
    load = 1'b0;
    check("load_at_wrap_tick", tick, 1);
    check("load_at_wrap_busy", busy_reload, 1);
    wait_tick(100, n); check("load_at_wrap_old", n, 10);
    check("load_at_wrap_busy_clear", busy_reload, 0);
    wait_tick(100, n); check("load_at_wrap_new", n, 5);
    $display("reload: 54 -> 9 -> 4 sequence done");

    // Reset mid-period with a pending load
    repeat (3) step();
    dvsr_int = 16'd20; load = 1'b1;
    step();
    load = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_tick", tick, 0);
    check("midreset_bit", bit_tick, 0);
    check("midreset_busy", busy_reload, 0);
    wait_tick(100, n); check("midreset_default_div", n, 55);

    // Resync at cnt=30, sub=7
    repeat (6) wait_tick(100, n);
    repeat (30) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("resync_no_tick", tick, 0);
    early = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(100, n);
      if (k == 1) check("resync_first", n, 55);
      if (k < 16) early += bit_tick;
      else check("resync_bit_16th", bit_tick, 1);
    end
    check("resync_bit_early", early, 0);

    // Resync landing on the boundary cycle suppresses that tick
    repeat (54) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("resync_at_wrap_no_tick", tick, 0);
    wait_tick(100, n); check("resync_at_wrap_next", n, 55);
    $display("resync: phase realigned");

    // Enable gating at cnt=40
    repeat (40) step();
    en = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      bad += tick;
    end
    check("en_low_no_ticks", bad, 0);
    en = 1'b1;
    wait_tick(100, n); check("en_resume", n, 15);

    // Divisor table: activate with en low, resync, measure steady-state periods
    foreach (vecs[i]) begin
      en = 1'b0;
      dvsr_int = 16'(vecs[i].dv_int); dvsr_frac = 4'(vecs[i].dv_frac);
      load = 1'b1;
      step();
      load = 1'b0;
      step();
      check("act_with_en_low", busy_reload, 0);
      resync = 1'b1;
      step();
      resync = 1'b0;
      en = 1'b1;
      wait_tick(vecs[i].dv_int + 10, n);
      check("vec_first_period", n, vecs[i].dv_int + 1);
      sum = 0; nlong = 0;
      for (int k = 0; k < vecs[i].nper; k++) begin
        wait_tick(vecs[i].dv_int + 10, n);
        sum += (n < 0) ? 100000 : n;
        if (n == vecs[i].dv_int + 2) nlong++;
      end
      check("vec_sum", sum, vecs[i].exp_sum);
      check("vec_long", nlong, vecs[i].exp_long);
      $display("vec %0d: int=%0d frac=%0d periods=%0d sum=%0d long=%0d",
               i, vecs[i].dv_int, vecs[i].dv_frac, vecs[i].nper, sum, nlong);
    end

    // Maximum integer divisor
    en = 1'b0;
    dvsr_int = 16'hFFFF; dvsr_frac = 4'd0;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    en = 1'b1;
    wait_tick(70000, n);
    check("max_divisor_period", n, 65536);
    $display("max divisor: period %0d", n);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
